// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request at a time, responses
// land in a small prefetch FIFO; supports redirect flush and sticky halt.
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               hlt_in,
  output logic               halted,
  output logic [ADDR_W-1:0]  fetch_pc
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HALT} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  state_t                  state, state_nxt;
  entry_t [DEPTH-1:0]      fifo_q;
  logic   [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic   [CNT_W-1:0]      count;
  logic   [ADDR_W-1:0]     req_pc;
  logic                    discard, halt_pend;
  logic                    halting, redirect, grant, push, pop, flush;

  // Halt wins over a same-cycle redirect; nothing but reset acts in HALT.
  assign halting  = (hlt_in | halt_pend) & (state != S_HALT);
  assign redirect = redirect_valid & ~halting & (state != S_HALT);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_REQ;
    else        state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:   if (halting)          state_nxt = S_HALT;
               else if (grant)       state_nxt = S_WAIT;
      S_WAIT:  if (imem_rvalid)      state_nxt = halting ? S_HALT : S_REQ;
      S_HALT:                        state_nxt = S_HALT;
      default:                       state_nxt = S_REQ;
    endcase
  end

  // FSM outputs; imem_req is held low while reset is asserted
  always_comb begin
    imem_req    = rst_n & (state == S_REQ) & (count < CNT_W'(DEPTH)) & ~halting;
    grant       = imem_req & imem_gnt;
    push        = (state == S_WAIT) & imem_rvalid & ~discard & ~halting & ~redirect;
    halted      = (state == S_HALT);
    instr_valid = (count != '0) & ~halted;
    pop         = instr_valid & instr_ready;
    flush       = redirect | ((state != S_HALT) & (state_nxt == S_HALT));
  end

  assign imem_addr = fetch_pc;
  assign instr     = fifo_q[rd_ptr].instr;
  assign instr_pc  = fifo_q[rd_ptr].pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_PC;
      req_pc    <= RESET_PC;
      discard   <= 1'b0;
      halt_pend <= 1'b0;
    end else begin
      // a redirected grant does not bump fetch_pc
      if (redirect)   fetch_pc <= redirect_pc;
      else if (grant) fetch_pc <= fetch_pc + 1'b1;
      if (grant) req_pc <= fetch_pc;
      if ((state == S_WAIT) & imem_rvalid)
        discard <= 1'b0;
      else if (((state == S_WAIT) & (redirect | halting)) | (redirect & grant))
        discard <= 1'b1;
      if (hlt_in & (state != S_HALT)) halt_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{pc: req_pc, instr: imem_rdata};
  end
endmodule
